// File: rtl/ysyx_24100005_imem_responder.sv
// Instruction-memory responder: one fetch at a time, word array preloaded through the ld_* port.
// Latency: rsp_valid rises LATENCY+1 cycles after the request handshake; no request overlap.
// Backpressure: holds the response (outputs frozen) until rsp_ready; req_ready is low outside IDLE.
module ysyx_24100005_imem_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_idx,
    input  logic [31:0]           ld_data
);

    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [3:0]  LAT_INIT = 4'(LATENCY);

    // The wait counter is four bits wide; larger latencies cannot be represented.
    if (LATENCY < 0 || LATENCY > 15) begin : g_latency_check
        $error("ysyx_24100005_imem_responder: LATENCY must be in 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic [31:0]             mem [DEPTH];

    logic [31:0]             off;
    logic                    in_range;
    logic                    aligned;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    req_fire;
    logic                    rsp_fire;

    // Address decode: offset from the base wraps, so PCs below BASE_ADDR land far out of range.
    assign off      = req_addr - BASE_ADDR;
    assign in_range = {1'b0, off} < (33'd4 << DEPTH_LOG2);
    assign aligned  = (req_addr[1:0] == 2'b00);
    assign rd_idx   = off[DEPTH_LOG2+1:2];
    assign req_fire = req_valid & req_ready;
    assign rsp_fire = rsp_valid & rsp_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_fire) begin
                    state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic; req_ready is also held low while reset is asserted.
    always_comb begin
        req_ready = (state == S_IDLE) && rst;
        rsp_valid = (state == S_RESP);
    end

    // Wait counter: loaded on accept, counts down while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if (req_fire) begin
            cnt <= LAT_INIT;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response registers snapshot the array at accept, so later preloads cannot alter them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data <= 32'h0;
            rsp_err  <= 1'b0;
        end else if (req_fire) begin
            rsp_data <= (in_range && aligned) ? mem[rd_idx] : EBREAK;
            rsp_err  <= !(in_range && aligned);
        end
    end

    // Preload write port; a same-cycle accept reads the old word because the write lands at the edge.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_imem_responder.sv
module tb_ysyx_24100005_imem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [1:0]  rsp_err;
    logic [31:0] req_addr [2];
    logic [31:0] rsp_data [2];
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [1024];

    always #5 clk = ~clk;

    // Instance 0: LATENCY=2, instance 1: LATENCY=0. Both share clock, reset and preload port.
    ysyx_24100005_imem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_LOG2(10), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    ysyx_24100005_imem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_LOG2(10), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    // Reference: {err, data} straight from the decode rules on a 4 KiB window at 0x8000_0000.
    function automatic logic [32:0] model_rsp(input logic [31:0] a);
        logic [31:0] o;
        o = a - 32'h8000_0000;
        if (a[1:0] == 2'b00 && o < 32'd4096) return {1'b0, model_mem[o[11:2]]};
        return {1'b1, 32'h0010_0073};
    endfunction

    task automatic load_word(input logic [9:0] i, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = i; ld_data = d;
        model_mem[i] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Issue one request and wait for rsp_valid; returns the cycle count from the accept edge.
    // ld_at>=0 issues a preload so that it lands ld_at cycles after the accept edge (0 = same edge).
    task automatic fetch(input int s, input logic [31:0] a, input int ld_at, input logic [9:0] li,
                         input logic [31:0] ldd, output logic [31:0] d, output logic e,
                         output int lat, output bit to);
        int n;
        to = 1'b0; d = 32'h0; e = 1'b0; lat = 0;
        @(negedge clk);
        n = 0;
        while (!req_ready[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[s]) begin
            to = 1'b1;
            return;
        end
        req_valid[s] = 1'b1; req_addr[s] = a; rsp_ready[s] = 1'b0;
        if (ld_at == 0) begin
            ld_en = 1'b1; ld_idx = li; ld_data = ldd;
            model_mem[li] = ldd;
        end
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0; req_addr[s] = $urandom; ld_en = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            ld_en = 1'b0;
            if (rsp_valid[s]) break;
            if (lat >= 40) begin
                to = 1'b1;
                break;
            end
            if (ld_at == lat) begin
                ld_en = 1'b1; ld_idx = li; ld_data = ldd;
                model_mem[li] = ldd;
            end
        end
        d = rsp_data[s];
        e = rsp_err[s];
    endtask

    task automatic release_rsp(input int s);
        rsp_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[s] = 1'b0;
    endtask

    task automatic test_reset;
        #22;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (req_ready[s] !== 1'b0) begin failures++; $display("FAIL reset_req_ready s=%0d got=%b exp=0", s, req_ready[s]); end
            checks++;
            if (rsp_valid[s] !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid s=%0d got=%b exp=0", s, rsp_valid[s]); end
            checks++;
            if (rsp_data[s] !== 32'h0 || rsp_err[s] !== 1'b0) begin
                failures++; $display("FAIL reset_rsp_regs s=%0d got=%h/%b exp=0/0", s, rsp_data[s], rsp_err[s]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (req_ready[s] !== 1'b1 || rsp_valid[s] !== 1'b0) begin
                failures++; $display("FAIL post_reset_idle s=%0d got rdy=%b vld=%b exp 1/0", s, req_ready[s], rsp_valid[s]);
            end
        end
    endtask

    task automatic test_preload_all;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_idx = 10'(i); ld_data = $urandom;
            model_mem[i] = ld_data;
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic test_basic;
        logic [31:0] d; logic e; int lat; bit to;
        load_word(10'd0, 32'h0000_0413);
        fetch(0, 32'h8000_0000, -1, 10'd0, 32'h0, d, e, lat, to);
        checks++;
        if (to || lat != 3) begin failures++; $display("FAIL basic_latency got=%0d timeout=%0b exp=3", lat, to); end
        checks++;
        if (d !== 32'h0000_0413 || e !== 1'b0) begin failures++; $display("FAIL basic_data got=%h/%b exp=00000413/0", d, e); end
        release_rsp(0);
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            failures++; $display("FAIL basic_return_idle got vld=%b rdy=%b exp 0/1", rsp_valid[0], req_ready[0]);
        end
    endtask

    task automatic test_decode;
        logic [31:0] addrs [5];
        logic [32:0] exp;
        logic [31:0] d; logic e; int lat; bit to;
        addrs[0] = 32'h8000_0002;
        addrs[1] = 32'h8000_1000;
        addrs[2] = 32'h7FFF_FFFC;
        addrs[3] = 32'h8000_0FFC;
        addrs[4] = 32'h8000_0FFF;
        for (int k = 0; k < 5; k++) begin
            exp = model_rsp(addrs[k]);
            fetch(0, addrs[k], -1, 10'd0, 32'h0, d, e, lat, to);
            checks++;
            if (to || {e, d} !== exp) begin
                failures++; $display("FAIL decode addr=%h got=%b/%h exp=%b/%h to=%0b", addrs[k], e, d, exp[32], exp[31:0], to);
            end
            release_rsp(0);
        end
        checks++;
        if (model_rsp(32'h8000_1000) !== {1'b1, 32'h0010_0073}) begin failures++; $display("FAIL decode_model_oob"); end
    endtask

    task automatic test_backpressure;
        logic [31:0] d; logic e; int lat; bit to;
        fetch(0, 32'h8000_0000, -1, 10'd0, 32'h0, d, e, lat, to);
        checks++;
        if (to) begin failures++; $display("FAIL bp_timeout got=1 exp=0"); end
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h8000_0004;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== d || rsp_err[0] !== e || req_ready[0] !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall c=%0d got vld=%b data=%h rdy=%b exp 1/%h/0", c, rsp_valid[0], rsp_data[0], req_ready[0], d);
            end
        end
        req_valid[0] = 1'b0;
        release_rsp(0);
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            failures++; $display("FAIL bp_release got vld=%b rdy=%b exp 0/1", rsp_valid[0], req_ready[0]);
        end
    endtask

    task automatic test_snapshot;
        logic [31:0] d; logic e; int lat; bit to;
        load_word(10'd5, 32'hAAAA_AAAA);
        fetch(0, 32'h8000_0014, 1, 10'd5, 32'h5555_5555, d, e, lat, to);
        checks++;
        if (to || d !== 32'hAAAA_AAAA) begin failures++; $display("FAIL snapshot_wait got=%h exp=aaaaaaaa", d); end
        release_rsp(0);
        fetch(0, 32'h8000_0014, -1, 10'd0, 32'h0, d, e, lat, to);
        checks++;
        if (to || d !== 32'h5555_5555) begin failures++; $display("FAIL snapshot_next got=%h exp=55555555", d); end
        release_rsp(0);
        load_word(10'd6, 32'h1234_5678);
        fetch(0, 32'h8000_0018, 0, 10'd6, 32'h8765_4321, d, e, lat, to);
        checks++;
        if (to || d !== 32'h1234_5678) begin failures++; $display("FAIL same_cycle_old got=%h exp=12345678", d); end
        release_rsp(0);
        fetch(0, 32'h8000_0018, -1, 10'd0, 32'h0, d, e, lat, to);
        checks++;
        if (to || d !== 32'h8765_4321) begin failures++; $display("FAIL same_cycle_new got=%h exp=87654321", d); end
        release_rsp(0);
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic e; int lat; bit to;
        // Reset while waiting.
        @(negedge clk);
        req_valid[0] = 1'b1; req_addr[0] = 32'h8000_0000;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin
            failures++; $display("FAIL mid_wait_state got rdy=%b vld=%b exp 0/0", req_ready[0], rsp_valid[0]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0 || rsp_data[0] !== 32'h0) begin
            failures++; $display("FAIL rst_wait got vld=%b rdy=%b data=%h exp 0/0/0", rsp_valid[0], req_ready[0], rsp_data[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
                failures++; $display("FAIL rst_wait_stale c=%0d got vld=%b rdy=%b exp 0/1", c, rsp_valid[0], req_ready[0]);
            end
        end
        // Reset while presenting a response.
        fetch(0, 32'h8000_0000, -1, 10'd0, 32'h0, d, e, lat, to);
        checks++;
        if (to || d !== model_mem[0]) begin failures++; $display("FAIL rst_resp_pre got=%h exp=%h", d, model_mem[0]); end
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || rsp_data[0] !== 32'h0 || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            failures++; $display("FAIL rst_resp got vld=%b data=%h rdy=%b exp 0/0/0", rsp_valid[0], rsp_data[0], req_ready[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
                failures++; $display("FAIL rst_resp_stale c=%0d got vld=%b rdy=%b exp 0/1", c, rsp_valid[0], req_ready[0]);
            end
        end
    endtask

    task automatic test_back_to_back_lat0;
        logic [31:0] d; logic e; int lat; bit to;
        load_word(10'd0, 32'h0000_0413);
        load_word(10'd1, 32'h0040_0493);
        load_word(10'd2, 32'h0080_0513);
        for (int k = 0; k < 3; k++) begin
            fetch(1, 32'h8000_0000 + 32'(4 * k), -1, 10'd0, 32'h0, d, e, lat, to);
            checks++;
            if (to || lat != 1) begin failures++; $display("FAIL lat0_latency k=%0d got=%0d exp=1", k, lat); end
            checks++;
            if (d !== model_mem[k] || e !== 1'b0) begin failures++; $display("FAIL lat0_data k=%0d got=%h exp=%h", k, d, model_mem[k]); end
            release_rsp(1);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, d;
        logic [32:0] exp;
        logic e; int lat, s, ld_at, stall; bit to;
        logic [9:0] li;
        for (int it = 0; it < 60; it++) begin
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0, 1:    a = 32'h8000_0000 + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                2:       a = 32'h8000_0000 + 32'($urandom_range(0, 4095)) | 32'h1;
                default: a = $urandom;
            endcase
            li    = ($urandom_range(0, 1) == 1) ? 10'(a[11:2]) : 10'($urandom_range(0, 1023));
            ld_at = int'($urandom_range(0, 3)) - 1;
            exp   = model_rsp(a);
            fetch(s, a, ld_at, li, $urandom, d, e, lat, to);
            checks++;
            if (to || {e, d} !== exp) begin
                failures++; $display("FAIL rand_data it=%0d s=%0d addr=%h got=%b/%h exp=%b/%h", it, s, a, e, d, exp[32], exp[31:0]);
            end
            checks++;
            if (lat != ((s == 1) ? 1 : 3)) begin failures++; $display("FAIL rand_latency it=%0d s=%0d got=%0d", it, s, lat); end
            stall = $urandom_range(0, 3);
            for (int c = 0; c < stall; c++) begin
                @(negedge clk);
                checks++;
                if (rsp_valid[s] !== 1'b1 || rsp_data[s] !== d || req_ready[s] !== 1'b0) begin
                    failures++; $display("FAIL rand_stall it=%0d got vld=%b data=%h exp 1/%h", it, rsp_valid[s], rsp_data[s], d);
                end
            end
            release_rsp(s);
            @(negedge clk);
            checks++;
            if (rsp_valid[s] !== 1'b0 || req_ready[s] !== 1'b1) begin
                failures++; $display("FAIL rand_idle it=%0d got vld=%b rdy=%b exp 0/1", it, rsp_valid[s], req_ready[s]);
            end
        end
    endtask

    initial begin
        req_valid   = 2'b00;
        rsp_ready   = 2'b00;
        req_addr[0] = 32'h0;
        req_addr[1] = 32'h0;
        ld_en       = 1'b0;
        ld_idx      = 10'h0;
        ld_data     = 32'h0;
        test_reset;
        test_preload_all;
        test_basic;
        test_decode;
        test_backpressure;
        test_snapshot;
        test_reset_mid;
        test_back_to_back_lat0;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
